// File: rtl/qlearn_pkg.sv
// Shared types and fixed-point helpers for the Q-learning update pipeline.
package qlearn_pkg;

  typedef enum logic [1:0] {
    ACT_LEFT  = 2'b00,
    ACT_UP    = 2'b01,
    ACT_RIGHT = 2'b10,
    ACT_DOWN  = 2'b11
  } action_e;

  localparam int DEF_X_W = 3;
  localparam int DEF_Y_W = 3;

  typedef struct packed {
    logic [DEF_X_W-1:0] x;
    logic [DEF_Y_W-1:0] y;
  } grid_pos_t;

  function automatic logic [31:0] one_of(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  // Rates above 1.0 are meaningless for alpha/gamma, so they are pinned to ONE.
  function automatic logic [31:0] clamp_one(input logic [31:0] v, input int unsigned frac);
    logic [31:0] one;
    one = one_of(frac);
    return (v > one) ? one : v;
  endfunction

  function automatic logic [63:0] sat_unsigned(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/qlearn_update_pipe_if.sv
// Transition input, update report output and quasi-static rate configuration.
interface qlearn_update_pipe_if #(
  parameter int DATA_W = 8,
  parameter int S_W    = 6
);
  logic [DATA_W-1:0] alpha;
  logic [DATA_W-1:0] gamma;

  logic              s_valid;
  logic              s_ready;
  logic [S_W-1:0]    s_state;
  logic [1:0]        s_action;
  logic [DATA_W-1:0] s_reward;

  logic              m_valid;
  logic [S_W-1:0]    m_state;
  logic [1:0]        m_action;
  logic [S_W-1:0]    m_next;
  logic [DATA_W-1:0] m_q;
  logic              m_done;

  modport master (
    output alpha, gamma, s_valid, s_state, s_action, s_reward,
    input  s_ready, m_valid, m_state, m_action, m_next, m_q, m_done
  );

  modport slave (
    input  alpha, gamma, s_valid, s_state, s_action, s_reward,
    output s_ready, m_valid, m_state, m_action, m_next, m_q, m_done
  );
endinterface

// File: rtl/qlearn_grid_step.sv
// Combinational grid move: applies an action to a {x,y} state, holding position at walls.
module qlearn_grid_step
  import qlearn_pkg::*;
#(
  parameter int X_W = 3,
  parameter int Y_W = 3
) (
  input  logic [X_W+Y_W-1:0] cur_state,
  input  logic [1:0]         action,
  output logic [X_W+Y_W-1:0] next_state
);
  localparam int S_W = X_W + Y_W;

  logic [X_W-1:0] x, x_n;
  logic [Y_W-1:0] y, y_n;

  assign x = cur_state[S_W-1:Y_W];
  assign y = cur_state[Y_W-1:0];

  // No wrap-around: a move off the edge leaves the coordinate unchanged.
  always_comb begin
    x_n = x;
    y_n = y;
    case (action_e'(action))
      ACT_LEFT:  if (x != '0)             x_n = x - X_W'(1);
      ACT_UP:    if (y != '0)             y_n = y - Y_W'(1);
      ACT_RIGHT: if (x != {X_W{1'b1}})    x_n = x + X_W'(1);
      ACT_DOWN:  if (y != {Y_W{1'b1}})    y_n = y + Y_W'(1);
      default: ;
    endcase
  end

  assign next_state = {x_n, y_n};

endmodule

// File: rtl/qlearn_update_pipe.sv
// Four-stage Q-learning update engine with register-held Q/Qmax tables and state-hazard stalling.
module qlearn_update_pipe
  import qlearn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC   = 4,
  parameter int X_W    = 3,
  parameter int Y_W    = 3,
  parameter int S_W    = X_W + Y_W
) (
  input  logic               clk,
  input  logic               rst_n,
  qlearn_update_pipe_if.slave bus
);
  localparam int STATES  = 1 << S_W;
  localparam int ENTRIES = STATES * 4;
  localparam int PW      = 2 * DATA_W;
  localparam int AW      = 2 * DATA_W + 2;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(one_of(FRAC));

  logic [DATA_W-1:0] q_tab_q    [ENTRIES];
  logic [DATA_W-1:0] q_tab_d    [ENTRIES];
  logic [DATA_W-1:0] qmax_tab_q [STATES];
  logic [DATA_W-1:0] qmax_tab_d [STATES];

  logic              ready_q, ready_d;

  logic              p1_valid_q, p1_valid_d;
  logic [S_W-1:0]    p1_state_q, p1_state_d, p1_next_q, p1_next_d;
  logic [1:0]        p1_action_q, p1_action_d;
  logic [DATA_W-1:0] p1_reward_q, p1_reward_d;

  logic              p2_valid_q, p2_valid_d;
  logic [S_W-1:0]    p2_state_q, p2_state_d, p2_next_q, p2_next_d;
  logic [1:0]        p2_action_q, p2_action_d;
  logic [DATA_W-1:0] p2_reward_q, p2_reward_d, p2_qv_q, p2_qv_d;

  logic              p3_valid_q, p3_valid_d;
  logic [S_W-1:0]    p3_state_q, p3_state_d, p3_next_q, p3_next_d;
  logic [1:0]        p3_action_q, p3_action_d;
  logic [PW-1:0]     p3_t1_q, p3_t1_d, p3_t2_q, p3_t2_d;
  logic [DATA_W-1:0] p3_ag_q, p3_ag_d, p3_qmax_q, p3_qmax_d;

  logic              m_valid_q, m_valid_d, m_done_q, m_done_d;
  logic [S_W-1:0]    m_state_q, m_state_d, m_next_q, m_next_d;
  logic [1:0]        m_action_q, m_action_d;
  logic [DATA_W-1:0] m_q_q, m_q_d;

  logic [S_W-1:0]    s_next;
  logic [DATA_W-1:0] alpha_c, gamma_c, q_new;
  logic [PW-1:0]     t3;
  logic [AW-1:0]     acc;
  logic              hazard, s_ready, accept;

  qlearn_grid_step #(.X_W(X_W), .Y_W(Y_W)) u_step (
    .cur_state  (bus.s_state),
    .action     (bus.s_action),
    .next_state (s_next)
  );

  assign alpha_c = DATA_W'(clamp_one(32'(bus.alpha), FRAC));
  assign gamma_c = DATA_W'(clamp_one(32'(bus.gamma), FRAC));

  // Any in-flight entry that will write the incoming state's Q row or the Qmax it reads blocks acceptance.
  always_comb begin
    hazard = 1'b0;
    if (p1_valid_q && (p1_state_q == bus.s_state || p1_state_q == s_next)) hazard = 1'b1;
    if (p2_valid_q && (p2_state_q == bus.s_state || p2_state_q == s_next)) hazard = 1'b1;
    if (p3_valid_q && (p3_state_q == bus.s_state || p3_state_q == s_next)) hazard = 1'b1;
  end

  assign s_ready = ready_q & ~hazard;
  assign accept  = bus.s_valid & s_ready;

  assign t3    = PW'(p3_ag_q) * PW'(p3_qmax_q);
  assign acc   = AW'(p3_t1_q) + AW'(p3_t2_q) + AW'(t3);
  assign q_new = DATA_W'(sat_unsigned(64'(acc >> FRAC), DATA_W));

  always_comb begin
    ready_d     = 1'b1;
    q_tab_d     = q_tab_q;
    qmax_tab_d  = qmax_tab_q;

    p1_valid_d  = accept;
    p1_state_d  = p1_state_q;
    p1_action_d = p1_action_q;
    p1_reward_d = p1_reward_q;
    p1_next_d   = p1_next_q;
    if (accept) begin
      p1_state_d  = bus.s_state;
      p1_action_d = bus.s_action;
      p1_reward_d = bus.s_reward;
      p1_next_d   = s_next;
    end

    p2_valid_d  = p1_valid_q;
    p2_state_d  = p2_state_q;
    p2_action_d = p2_action_q;
    p2_reward_d = p2_reward_q;
    p2_next_d   = p2_next_q;
    p2_qv_d     = p2_qv_q;
    if (p1_valid_q) begin
      p2_state_d  = p1_state_q;
      p2_action_d = p1_action_q;
      p2_reward_d = p1_reward_q;
      p2_next_d   = p1_next_q;
      p2_qv_d     = q_tab_q[{p1_state_q, p1_action_q}];
    end

    p3_valid_d  = p2_valid_q;
    p3_state_d  = p3_state_q;
    p3_action_d = p3_action_q;
    p3_next_d   = p3_next_q;
    p3_t1_d     = p3_t1_q;
    p3_t2_d     = p3_t2_q;
    p3_ag_d     = p3_ag_q;
    p3_qmax_d   = p3_qmax_q;
    if (p2_valid_q) begin
      p3_state_d  = p2_state_q;
      p3_action_d = p2_action_q;
      p3_next_d   = p2_next_q;
      p3_t1_d     = PW'(ONE - alpha_c) * PW'(p2_qv_q);
      p3_t2_d     = PW'(alpha_c) * PW'(p2_reward_q);
      p3_ag_d     = DATA_W'((PW'(alpha_c) * PW'(gamma_c)) >> FRAC);
      p3_qmax_d   = qmax_tab_q[p2_next_q];
    end

    m_valid_d  = p3_valid_q;
    m_state_d  = m_state_q;
    m_action_d = m_action_q;
    m_next_d   = m_next_q;
    m_q_d      = m_q_q;
    m_done_d   = m_done_q;
    if (p3_valid_q) begin
      m_state_d  = p3_state_q;
      m_action_d = p3_action_q;
      m_next_d   = p3_next_q;
      m_q_d      = q_new;
      m_done_d   = &p3_next_q;
      q_tab_d[{p3_state_q, p3_action_q}] = q_new;
      if (q_new > qmax_tab_q[p3_state_q]) qmax_tab_d[p3_state_q] = q_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_tab_q     <= '{default: '0};
      qmax_tab_q  <= '{default: '0};
      ready_q     <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_state_q  <= '0;
      p1_action_q <= '0;
      p1_reward_q <= '0;
      p1_next_q   <= '0;
      p2_valid_q  <= 1'b0;
      p2_state_q  <= '0;
      p2_action_q <= '0;
      p2_reward_q <= '0;
      p2_next_q   <= '0;
      p2_qv_q     <= '0;
      p3_valid_q  <= 1'b0;
      p3_state_q  <= '0;
      p3_action_q <= '0;
      p3_next_q   <= '0;
      p3_t1_q     <= '0;
      p3_t2_q     <= '0;
      p3_ag_q     <= '0;
      p3_qmax_q   <= '0;
      m_valid_q   <= 1'b0;
      m_state_q   <= '0;
      m_action_q  <= '0;
      m_next_q    <= '0;
      m_q_q       <= '0;
      m_done_q    <= 1'b0;
    end else begin
      q_tab_q     <= q_tab_d;
      qmax_tab_q  <= qmax_tab_d;
      ready_q     <= ready_d;
      p1_valid_q  <= p1_valid_d;
      p1_state_q  <= p1_state_d;
      p1_action_q <= p1_action_d;
      p1_reward_q <= p1_reward_d;
      p1_next_q   <= p1_next_d;
      p2_valid_q  <= p2_valid_d;
      p2_state_q  <= p2_state_d;
      p2_action_q <= p2_action_d;
      p2_reward_q <= p2_reward_d;
      p2_next_q   <= p2_next_d;
      p2_qv_q     <= p2_qv_d;
      p3_valid_q  <= p3_valid_d;
      p3_state_q  <= p3_state_d;
      p3_action_q <= p3_action_d;
      p3_next_q   <= p3_next_d;
      p3_t1_q     <= p3_t1_d;
      p3_t2_q     <= p3_t2_d;
      p3_ag_q     <= p3_ag_d;
      p3_qmax_q   <= p3_qmax_d;
      m_valid_q   <= m_valid_d;
      m_state_q   <= m_state_d;
      m_action_q  <= m_action_d;
      m_next_q    <= m_next_d;
      m_q_q       <= m_q_d;
      m_done_q    <= m_done_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_state  = m_state_q;
  assign bus.m_action = m_action_q;
  assign bus.m_next   = m_next_q;
  assign bus.m_q      = m_q_q;
  assign bus.m_done   = m_done_q;

endmodule

// File: tb/tb_qlearn_update_pipe.sv
// Bench for qlearn_update_pipe: directed scenarios plus random transitions against a sequential Q-learning model.
module tb_qlearn_update_pipe;
  import qlearn_pkg::*;

  localparam int DATA_W = 8;
  localparam int FRAC   = 4;
  localparam int X_W    = 3;
  localparam int Y_W    = 3;
  localparam int S_W    = X_W + Y_W;
  localparam int ONE    = 1 << FRAC;
  localparam int QLIM   = (1 << DATA_W) - 1;
  localparam int XMAX   = (1 << X_W) - 1;
  localparam int YMAX   = (1 << Y_W) - 1;
  localparam int GOAL   = (1 << S_W) - 1;
  localparam int NST    = 1 << S_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  qlearn_update_pipe_if #(.DATA_W(DATA_W), .S_W(S_W)) bus ();

  qlearn_update_pipe #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .S_W    (S_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int st; int act; int nx; int q; int done; int acceptEdge; } expRec_t;
  typedef struct { int st; int nx; int q; int done; int cyc; } obsRec_t;
  typedef struct { int st; int acceptEdge; } flight_t;

  expRec_t expQ[$];
  obsRec_t obsQ[$];
  flight_t flightQ[$];
  int      qRef[NST*4];
  int      qmaxRef[NST];
  int      alphaVal, gammaVal;
  int      testsRun    = 0;
  int      testsFailed = 0;
  expRec_t monExp;
  obsRec_t monObs;

  task checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int stateOf(input int x, input int y);
    grid_pos_t p;
    p.x = DEF_X_W'(x);
    p.y = DEF_Y_W'(y);
    return int'(p);
  endfunction

  function automatic int nextOf(input int st, input int act);
    int x, y;
    x = st / (YMAX + 1);
    y = st % (YMAX + 1);
    case (act)
      0: if (x > 0)    x = x - 1;
      1: if (y > 0)    y = y - 1;
      2: if (x < XMAX) x = x + 1;
      default: if (y < YMAX) y = y + 1;
    endcase
    return x * (YMAX + 1) + y;
  endfunction

  function automatic int expReady(input int st, input int nx);
    foreach (flightQ[i])
      if ((cyc - flightQ[i].acceptEdge) <= 2 && (flightQ[i].st == st || flightQ[i].st == nx))
        return 0;
    return 1;
  endfunction

  task clearModel();
    foreach (qRef[i]) qRef[i] = 0;
    foreach (qmaxRef[i]) qmaxRef[i] = 0;
    expQ.delete();
    flightQ.delete();
  endtask

  task setRates(input int a, input int g);
    alphaVal  = a;
    gammaVal  = g;
    bus.alpha = DATA_W'(a);
    bus.gamma = DATA_W'(g);
  endtask

  // Applies one transition to the sequential model: Q' = (1-a)Q + a*r + (a*g)*Qmax[next].
  task modelAccept(input int st, input int act, input int rw, input int acceptEdge);
    int a, g, nx, qn;
    expRec_t e;
    flight_t f;
    a  = (alphaVal > ONE) ? ONE : alphaVal;
    g  = (gammaVal > ONE) ? ONE : gammaVal;
    nx = nextOf(st, act);
    qn = ((ONE - a) * qRef[st*4 + act] + a * rw + ((a * g) / ONE) * qmaxRef[nx]) / ONE;
    if (qn > QLIM) qn = QLIM;
    qRef[st*4 + act] = qn;
    if (qn > qmaxRef[st]) qmaxRef[st] = qn;
    e = '{st: st, act: act, nx: nx, q: qn, done: (nx == GOAL) ? 1 : 0, acceptEdge: acceptEdge};
    expQ.push_back(e);
    f = '{st: st, acceptEdge: acceptEdge};
    flightQ.push_back(f);
    if (flightQ.size() > 3) void'(flightQ.pop_front());
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input int st, input int act, input int rw, output int stalls);
    int nx, waited;
    nx     = nextOf(st, act);
    waited = 0;
    bus.s_valid  = 1'b1;
    bus.s_state  = S_W'(st);
    bus.s_action = 2'(act);
    bus.s_reward = DATA_W'(rw);
    #1;
    checkOutput("s_ready", int'(bus.s_ready), expReady(st, nx));
    while (bus.s_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
      checkOutput("s_ready", int'(bus.s_ready), expReady(st, nx));
    end
    stalls = waited;
    if (bus.s_ready !== 1'b1) checkOutput("accept_timeout", 0, 1);
    else modelAccept(st, act, rw, cyc + 1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task drainPipe();
    int w;
    w = 0;
    while (expQ.size() > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (expQ.size() > 0) begin
      checkOutput("drain_timeout", expQ.size(), 0);
      expQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task checkResetOutputs();
    checkOutput("rst_m_valid",  int'(bus.m_valid),  0);
    checkOutput("rst_m_state",  int'(bus.m_state),  0);
    checkOutput("rst_m_action", int'(bus.m_action), 0);
    checkOutput("rst_m_next",   int'(bus.m_next),   0);
    checkOutput("rst_m_q",      int'(bus.m_q),      0);
    checkOutput("rst_m_done",   int'(bus.m_done),   0);
    checkOutput("rst_s_ready",  int'(bus.s_ready),  0);
  endtask

  task checkObsQ(input string tag, input int idx, input int expV);
    if (idx < obsQ.size()) checkOutput(tag, obsQ[idx].q, expV);
    else checkOutput({tag, "_missing"}, 0, 1);
  endtask

  always @(negedge clk) begin
    if (bus.m_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_m_valid", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("m_state",  int'(bus.m_state),  monExp.st);
        checkOutput("m_action", int'(bus.m_action), monExp.act);
        checkOutput("m_next",   int'(bus.m_next),   monExp.nx);
        checkOutput("m_q",      int'(bus.m_q),      monExp.q);
        checkOutput("m_done",   int'(bus.m_done),   monExp.done);
        checkOutput("latency",  cyc,                monExp.acceptEdge + 3);
      end
      monObs = '{st: int'(bus.m_state), nx: int'(bus.m_next), q: int'(bus.m_q),
                 done: int'(bus.m_done), cyc: cyc};
      obsQ.push_back(monObs);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stalls;
    int streamSt[8];
    bus.s_valid  = 1'b0;
    bus.s_state  = '0;
    bus.s_action = '0;
    bus.s_reward = '0;
    setRates(2, 8);
    clearModel();

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
    #1 checkOutput("ready_before_first_edge", int'(bus.s_ready), 0);
    @(posedge clk);
    #1 checkOutput("ready_after_first_edge", int'(bus.s_ready), 1);
    @(negedge clk);

    // Reset with three transitions in flight, then revisit the same entries.
    applyStimulus(stateOf(3, 5), int'(ACT_RIGHT), 8'h10, stalls);
    applyStimulus(stateOf(5, 1), int'(ACT_UP),    8'h20, stalls);
    applyStimulus(stateOf(0, 7), int'(ACT_DOWN),  8'h30, stalls);
    rst_n = 1'b0;
    clearModel();
    #1 checkResetOutputs();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    obsQ.delete();
    applyStimulus(stateOf(3, 5), int'(ACT_RIGHT), 8'h10, stalls);
    applyStimulus(stateOf(5, 1), int'(ACT_UP),    8'h20, stalls);
    applyStimulus(stateOf(0, 7), int'(ACT_DOWN),  8'h30, stalls);
    drainPipe();
    checkOutput("post_reset_count", obsQ.size(), 3);
    checkObsQ("post_reset_q0", 0, 8'h02);
    checkObsQ("post_reset_q1", 1, 8'h04);
    checkObsQ("post_reset_q2", 2, 8'h06);

    // Single update followed by an immediate same-state resend.
    obsQ.delete();
    applyStimulus(stateOf(1, 1), int'(ACT_RIGHT), 8'h40, stalls);
    checkOutput("single_no_stall", stalls, 0);
    applyStimulus(stateOf(1, 1), int'(ACT_RIGHT), 8'h40, stalls);
    checkOutput("hazard_stall_cycles", stalls, 3);
    drainPipe();
    checkOutput("single_count", obsQ.size(), 2);
    checkObsQ("single_q", 0, 8'h08);
    if (obsQ.size() > 0) checkOutput("single_next", obsQ[0].nx, stateOf(2, 1));
    checkObsQ("repeat_q", 1, 8'h0F);

    // With alpha = gamma = ONE and zero reward, Q' equals Qmax of the next state.
    setRates(16, 16);
    obsQ.delete();
    applyStimulus(stateOf(1, 0), int'(ACT_DOWN), 0, stalls);
    drainPipe();
    checkObsQ("qmax_probe", 0, 8'h0F);

    // Walls and goal.
    setRates(2, 8);
    obsQ.delete();
    applyStimulus(stateOf(0, 3), int'(ACT_LEFT), 8'h20, stalls);
    applyStimulus(stateOf(7, 7), int'(ACT_DOWN), 8'h20, stalls);
    drainPipe();
    checkOutput("wall_count", obsQ.size(), 2);
    if (obsQ.size() > 1) begin
      checkOutput("wall_left_next", obsQ[0].nx, stateOf(0, 3));
      checkOutput("wall_left_done", obsQ[0].done, 0);
      checkOutput("goal_next", obsQ[1].nx, GOAL);
      checkOutput("goal_done", obsQ[1].done, 1);
    end

    // Saturation: Qmax[{4,4}] = 0x20, then r = 0xFF into {4,4}.
    setRates(16, 16);
    obsQ.delete();
    applyStimulus(stateOf(4, 4), int'(ACT_LEFT), 8'h20, stalls);
    applyStimulus(stateOf(4, 3), int'(ACT_DOWN), 8'hFF, stalls);
    drainPipe();
    checkObsQ("preload_q", 0, 8'h20);
    checkObsQ("saturated_q", 1, 8'hFF);

    // Streaming on even-x states moving right: no state or next collides within three slots.
    setRates(int'($urandom_range(0, 16)), int'($urandom_range(0, 16)));
    obsQ.delete();
    streamSt = '{stateOf(0, 0), stateOf(2, 2), stateOf(4, 4), stateOf(6, 6),
                 stateOf(0, 4), stateOf(2, 6), stateOf(4, 0), stateOf(6, 2)};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(streamSt[i], int'(ACT_RIGHT), int'($urandom_range(0, 255)), stalls);
      checkOutput("stream_no_stall", stalls, 0);
    end
    drainPipe();
    checkOutput("stream_count", obsQ.size(), 8);
    if (obsQ.size() == 8) begin
      for (int i = 1; i < 8; i++) begin
        checkOutput("stream_consecutive", obsQ[i].cyc, obsQ[0].cyc + i);
        checkOutput("stream_order", obsQ[i].st, streamSt[i]);
      end
    end

    // Random transitions, rates (including values above ONE) changed only between drained batches.
    for (int b = 0; b < 10; b++) begin
      setRates(int'($urandom_range(0, 32)), int'($urandom_range(0, 32)));
      for (int t = 0; t < 30; t++) begin
        applyStimulus(int'($urandom_range(0, NST - 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 255)), stalls);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      drainPipe();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
